// File: rtl/sar_data_collector_if.sv
// Bundle of the SAR data-collector signals: strobe/data capture inputs, FIFO consumer handshake, status.
// The slave side is the collector; the master side is whatever drives the SAR bus and drains the FIFO.
interface sar_data_collector_if #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [5:0]       data_i;
  logic             clk_data_i;
  logic             single_ended_i;
  logic             clr_i;
  logic             ready_i;
  logic [11:0]      code_o;
  logic             se_o;
  logic             valid_o;
  logic             overflow_o;
  logic             short_o;
  logic [LW-1:0]    level_o;
  logic [CNT_W-1:0] word_cnt_o;

  modport slave (
    input  data_i, clk_data_i, single_ended_i, clr_i, ready_i,
    output code_o, se_o, valid_o, overflow_o, short_o, level_o, word_cnt_o
  );

  modport master (
    output data_i, clk_data_i, single_ended_i, clr_i, ready_i,
    input  code_o, se_o, valid_o, overflow_o, short_o, level_o, word_cnt_o
  );
endinterface

// File: rtl/sar_data_collector.sv
// Assembles inverted SAR half-words into 12-bit codes and queues them in a first-word-fall-through FIFO.
//
// state  | meaning
// S_IDLE | waiting for a clean rising edge of the data strobe
// S_HIGH | upper half-word captured, waiting for the second strobe-high cycle
// S_LOW  | lower half-word being tracked; last strobe-high cycle wins, commit on strobe fall
module sar_data_collector #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_z,
  sar_data_collector_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

  state_t state_q, state_d;

  logic [5:0]       hi_q, lo_q;
  logic             strb_q;
  logic             armed_q;
  logic             hi_ld, lo_ld, commit, short_evt;
  logic             rise;

  logic [12:0]      mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic [CNT_W-1:0] word_cnt_q;
  logic             overflow_q, short_q;

  logic             full, valid, pop, push;
  logic [11:0]      code_c;
  logic             se_c;
  logic [12:0]      head;

  // armed_q blocks capture until the strobe has been seen low after reset
  assign rise = bus.clk_data_i & ~strb_q & armed_q;

  always_ff @(posedge clk or negedge rst_z) begin
    if (!rst_z) begin
      state_q <= S_IDLE;
      strb_q  <= 1'b0;
      armed_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      strb_q  <= bus.clk_data_i;
      if (!bus.clk_data_i) armed_q <= 1'b1;
      if (hi_ld) hi_q <= bus.data_i;
      if (lo_ld) lo_q <= bus.data_i;
    end
  end

  always_comb begin
    state_d   = state_q;
    hi_ld     = 1'b0;
    lo_ld     = 1'b0;
    commit    = 1'b0;
    short_evt = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rise) begin
          state_d = S_HIGH;
          hi_ld   = 1'b1;
        end
      end
      S_HIGH: begin
        if (bus.clk_data_i) begin
          state_d = S_LOW;
          lo_ld   = 1'b1;
        end else begin
          state_d   = S_IDLE;
          short_evt = 1'b1;
        end
      end
      S_LOW: begin
        if (bus.clk_data_i) begin
          lo_ld = 1'b1;
        end else begin
          state_d = S_IDLE;
          commit  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The SAR bus is inverted; single-ended mode has no sign bit
  assign se_c   = bus.single_ended_i;
  assign code_c = se_c ? {1'b0, ~hi_q[4:0], ~lo_q} : {~hi_q, ~lo_q};

  assign full  = (level_q == FULL_LVL);
  assign valid = (level_q != '0);
  assign pop   = valid & bus.ready_i;
  assign push  = commit & (~full | pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {se_c, code_c};
  end

  always_ff @(posedge clk or negedge rst_z) begin
    if (!rst_z) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // Clear wins over a same-cycle increment or flag set
  always_ff @(posedge clk or negedge rst_z) begin
    if (!rst_z) begin
      word_cnt_q <= '0;
      overflow_q <= 1'b0;
      short_q    <= 1'b0;
    end else if (bus.clr_i) begin
      word_cnt_q <= '0;
      overflow_q <= 1'b0;
      short_q    <= 1'b0;
    end else begin
      if (push)            word_cnt_q <= word_cnt_q + 1'b1;
      if (commit && !push) overflow_q <= 1'b1;
      if (short_evt)       short_q    <= 1'b1;
    end
  end

  assign head           = mem[rd_ptr_q];
  assign bus.code_o     = valid ? head[11:0] : 12'h000;
  assign bus.se_o       = valid ? head[12]   : 1'b0;
  assign bus.valid_o    = valid;
  assign bus.level_o    = level_q;
  assign bus.word_cnt_o = word_cnt_q;
  assign bus.overflow_o = overflow_q;
  assign bus.short_o    = short_q;
endmodule
